// File: rtl/door_pkg.sv
// Shared constants and types for the garage door controller and its input front end.
//   DefaultDebounceCycles : stable samples needed before a debounced level changes
//   DefaultCntW           : debounce counter width (2**DefaultCntW > DefaultDebounceCycles)
//   Door*Cycles           : door controller timing constants reused by the FSM bench
package door_pkg;

    localparam int unsigned DefaultDebounceCycles = 4;
    localparam int unsigned DefaultCntW           = 3;

    // Door controller timing, in clock cycles.
    localparam int unsigned DoorTravelCycles  = 64;
    localparam int unsigned DoorReverseCycles = 8;
    localparam int unsigned DoorTimeoutCycles = 128;

    typedef enum logic [2:0] {
        StClosed,
        StOpening,
        StOpen,
        StClosing,
        StStopped
    } door_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounced input channel: 2-flop synchroniser followed by a counter/stable pair.
// The stable level only follows the synchronised input after it has differed from
// the stable level for DEBOUNCE_CYCLES consecutive samples.
//   CLK        : system clock, rising edge
//   RST        : synchronous active-high reset
//   raw_in     : asynchronous, bouncy input
//   stable_out : debounced level
module debounce_ch
    import door_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CNT_W           = DefaultCntW
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_in,
    output logic stable_out
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // A return to the stable level at any point restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            s1_q     <= raw_in;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/door_input_conditioner.sv
// Front end for the garage door FSM: debounces the push button and both limit
// switches, flags both limits active at once, and emits an Activate rising-edge pulse.
//   CLK, RST       : clock and synchronous active-high reset
//   btn_raw        : raw push button
//   up_lim_raw     : raw upper limit switch
//   dn_lim_raw     : raw lower limit switch
//   Activate       : debounced button, forced low while LIMIT_FAULT
//   UP_MAX, DN_MAX : debounced limit levels
//   Activate_rise  : one-cycle pulse after the debounced button goes 0->1
//   LIMIT_FAULT    : registered, high while both debounced limits are 1
module door_input_conditioner
    import door_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CNT_W           = DefaultCntW
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    input  logic up_lim_raw,
    input  logic dn_lim_raw,
    output logic Activate,
    output logic UP_MAX,
    output logic DN_MAX,
    output logic Activate_rise,
    output logic LIMIT_FAULT
);

    logic act_stable;
    logic up_stable;
    logic dn_stable;

    logic fault_q;
    logic fault_d;
    logic act_prev_q;
    logic rise_q;
    logic rise_d;

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn (
        .CLK        (CLK),
        .RST        (RST),
        .raw_in     (btn_raw),
        .stable_out (act_stable)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_up (
        .CLK        (CLK),
        .RST        (RST),
        .raw_in     (up_lim_raw),
        .stable_out (up_stable)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dn (
        .CLK        (CLK),
        .RST        (RST),
        .raw_in     (dn_lim_raw),
        .stable_out (dn_stable)
    );

    // The pulse is also blocked on the edge where the fault is about to assert, so a
    // button edge coinciding with both limits settling never reaches the FSM.
    always_comb begin
        fault_d = up_stable & dn_stable;
        rise_d  = act_stable & ~act_prev_q & ~fault_d & ~fault_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_q    <= 1'b0;
            act_prev_q <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            fault_q    <= fault_d;
            act_prev_q <= act_stable;
            rise_q     <= rise_d;
        end
    end

    assign Activate      = act_stable & ~fault_q;
    assign UP_MAX        = up_stable;
    assign DN_MAX        = dn_stable;
    assign Activate_rise = rise_q;
    assign LIMIT_FAULT   = fault_q;

endmodule

// File: tb/tb_door_input_conditioner.sv
module tb_door_input_conditioner;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic btn_raw = 1'b0;
    logic up_lim_raw = 1'b0;
    logic dn_lim_raw = 1'b0;
    logic Activate;
    logic UP_MAX;
    logic DN_MAX;
    logic Activate_rise;
    logic LIMIT_FAULT;

    int tests = 0;
    int fails = 0;

    door_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .btn_raw       (btn_raw),
        .up_lim_raw    (up_lim_raw),
        .dn_lim_raw    (dn_lim_raw),
        .Activate      (Activate),
        .UP_MAX        (UP_MAX),
        .DN_MAX        (DN_MAX),
        .Activate_rise (Activate_rise),
        .LIMIT_FAULT   (LIMIT_FAULT)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge; outputs are sampled and inputs driven 1ns after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        btn_raw    = 1'b0;
        up_lim_raw = 1'b0;
        dn_lim_raw = 1'b0;
        RST        = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        btn_raw    = 1'b1;
        up_lim_raw = 1'b1;
        dn_lim_raw = 1'b1;
        RST        = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
            tests++;
            if (outs !== 5'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: outputs=%b expected 00000", i, outs);
            end
        end
        RST = 1'b0;
        // Edges 1..5 after release: nothing may appear yet.
        for (int i = 1; i <= 5; i++) begin
            step();
            outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
            tests++;
            if (outs !== 5'b0) begin
                fails++;
                $display("FAIL reset_release_edge%0d: outputs=%b expected 00000", i, outs);
            end
        end
        step(); // edge 6
        outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
        tests++;
        if (outs !== 5'b11100) begin
            fails++;
            $display("FAIL reset_edge6: outputs=%b expected 11100", outs);
        end
        step(); // edge 7: fault registers, Activate forced low, no pulse
        outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
        tests++;
        if (outs !== 5'b01101) begin
            fails++;
            $display("FAIL reset_edge7_fault: outputs=%b expected 01101", outs);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
            tests++;
            if (outs !== 5'b01101) begin
                fails++;
                $display("FAIL reset_fault_hold[%0d]: outputs=%b expected 01101", i, outs);
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        btn_raw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            tests++;
            if (Activate !== 1'b0) begin
                fails++;
                $display("FAIL press_early_edge%0d: Activate=%b expected 0", i, Activate);
            end
        end
        step();
        tests++;
        if ({Activate, Activate_rise} !== 2'b10) begin
            fails++;
            $display("FAIL press_edge6: Activate,rise=%b expected 10", {Activate, Activate_rise});
        end
        step();
        tests++;
        if ({Activate, Activate_rise} !== 2'b11) begin
            fails++;
            $display("FAIL press_pulse: Activate,rise=%b expected 11", {Activate, Activate_rise});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({Activate, Activate_rise} !== 2'b10) begin
                fails++;
                $display("FAIL press_held[%0d]: Activate,rise=%b expected 10", i,
                         {Activate, Activate_rise});
            end
        end
        // Release: falls after six edges and never pulses.
        btn_raw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            tests++;
            if ({Activate, Activate_rise} !== {(i < 6), 1'b0}) begin
                fails++;
                $display("FAIL release_edge%0d: Activate,rise=%b expected %b", i,
                         {Activate, Activate_rise}, {(i < 6), 1'b0});
            end
        end
    endtask

    task automatic test_bounce();
        int rises;
        logic seen_act;
        do_reset();
        rises    = 0;
        seen_act = 1'b0;
        for (int i = 0; i < 8; i++) begin
            btn_raw = (i % 2 == 0);
            step();
            seen_act |= Activate;
            rises += int'(Activate_rise);
        end
        tests++;
        if (seen_act !== 1'b0) begin
            fails++;
            $display("FAIL bounce_no_activate: Activate seen=%b expected 0", seen_act);
        end
        btn_raw = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            rises += int'(Activate_rise);
            if (i == 5) begin
                tests++;
                if (Activate !== 1'b0) begin
                    fails++;
                    $display("FAIL bounce_edge5: Activate=%b expected 0", Activate);
                end
            end
            if (i == 6) begin
                tests++;
                if (Activate !== 1'b1) begin
                    fails++;
                    $display("FAIL bounce_edge6: Activate=%b expected 1", Activate);
                end
            end
        end
        tests++;
        if (rises != 1) begin
            fails++;
            $display("FAIL bounce_rise_count: pulses=%0d expected 1", rises);
        end
    endtask

    task automatic test_glitch();
        logic seen_up;
        do_reset();
        seen_up    = 1'b0;
        up_lim_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            seen_up |= UP_MAX;
        end
        up_lim_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen_up |= UP_MAX;
        end
        tests++;
        if (seen_up !== 1'b0) begin
            fails++;
            $display("FAIL glitch_reject: UP_MAX seen=%b expected 0", seen_up);
        end
    endtask

    task automatic test_limit_fault();
        logic [4:0] outs;
        do_reset();
        btn_raw = 1'b1;
        for (int i = 0; i < 8; i++) step();
        up_lim_raw = 1'b1;
        dn_lim_raw = 1'b1;
        for (int i = 0; i < 5; i++) step();
        outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
        tests++;
        if (outs !== 5'b10000) begin
            fails++;
            $display("FAIL fault_limits_edge5: outputs=%b expected 10000", outs);
        end
        step();
        outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
        tests++;
        if (outs !== 5'b11100) begin
            fails++;
            $display("FAIL fault_limits_edge6: outputs=%b expected 11100", outs);
        end
        step();
        outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
        tests++;
        if (outs !== 5'b01101) begin
            fails++;
            $display("FAIL fault_asserted: outputs=%b expected 01101", outs);
        end
        dn_lim_raw = 1'b0;
        for (int i = 0; i < 5; i++) step();
        outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
        tests++;
        if (outs !== 5'b01101) begin
            fails++;
            $display("FAIL fault_dn_drop_edge5: outputs=%b expected 01101", outs);
        end
        step();
        outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
        tests++;
        if (outs !== 5'b01001) begin
            fails++;
            $display("FAIL fault_dn_drop_edge6: outputs=%b expected 01001", outs);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            outs = {Activate, UP_MAX, DN_MAX, Activate_rise, LIMIT_FAULT};
            tests++;
            if (outs !== 5'b11000) begin
                fails++;
                $display("FAIL fault_cleared[%0d]: outputs=%b expected 11000", i, outs);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        tests++;
        if (Activate !== 1'b0) begin
            fails++;
            $display("FAIL midreset_edge: Activate=%b expected 0", Activate);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            tests++;
            if (Activate !== (i == 6)) begin
                fails++;
                $display("FAIL midreset_release_edge%0d: Activate=%b expected %b", i, Activate,
                         (i == 6));
            end
        end
        step();
        tests++;
        if (Activate_rise !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pulse: Activate_rise=%b expected 1", Activate_rise);
        end
    endtask

    task automatic test_independent();
        do_reset();
        btn_raw    = 1'b1;
        up_lim_raw = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tests++;
        if ({Activate, UP_MAX, DN_MAX} !== 3'b000) begin
            fails++;
            $display("FAIL indep_edge5: act,up,dn=%b expected 000", {Activate, UP_MAX, DN_MAX});
        end
        step();
        tests++;
        if ({Activate, UP_MAX, DN_MAX, LIMIT_FAULT} !== 4'b1100) begin
            fails++;
            $display("FAIL indep_edge6: act,up,dn,fault=%b expected 1100",
                     {Activate, UP_MAX, DN_MAX, LIMIT_FAULT});
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_limit_fault();
        test_reset_mid_count();
        test_independent();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
